// File: rtl/rgmii_rx.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_rx
// Purpose  : RGMII receive front end. Turns IDDR-captured RXD/RX_CTL samples
//            into an unstallable AXI-Stream byte stream with frame error on
//            the last beat, and decodes the PHY in-band status during idle.
//            Handles 1000M (DDR bytes) and 10/100M (SDR nibbles).
// Revision : 1.0 - initial release
// ============================================================================
module rgmii_rx #(
  parameter bit STRIP_PREAMBLE = 1'b1
) (
  input  logic       rgmii_rxc,
  input  logic       reset,
  input  logic [3:0] rxd_rise,
  input  logic [3:0] rxd_fall,
  input  logic       rx_ctl_rise,
  input  logic       rx_ctl_fall,
  input  logic [1:0] phy_speed_status,
  output logic [7:0] rx_axis_rgmii_tdata,
  output logic       rx_axis_rgmii_tvalid,
  output logic       rx_axis_rgmii_tlast,
  output logic       rx_axis_rgmii_tuser,
  output logic       inband_link_status,
  output logic [1:0] inband_speed_status,
  output logic       inband_duplex_status
);

  localparam logic [1:0] SPEED_1000 = 2'd2;
  localparam logic [7:0] PRE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE   = 8'hD5;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    DATA      = 3'd3,
    DROP      = 3'd4
  } state_t;

  state_t     state;

  // S1: registered copy of the IDDR outputs
  logic [3:0] s1_rxd_rise;
  logic [3:0] s1_rxd_fall;
  logic       s1_dv;
  logic       s1_ctl_fall;

  // 10/100M nibble assembly
  logic       nib_phase;   // 1 = the next DV nibble is the high nibble
  logic [3:0] nib_low;
  logic       nib_err;

  // S2: one-byte holding buffer in front of the output register
  logic       s2_valid;
  logic [7:0] s2_data;

  logic       frame_err;   // sticky error since the frame started

  // Decode results from S1
  logic       gig;
  logic       cyc_err;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       odd_end;
  logic       beat_last;
  logic       beat_user;
  logic       load_s2;

  // Capture every IDDR input once before any decoding
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      s1_rxd_rise <= 4'h0;
      s1_rxd_fall <= 4'h0;
      s1_dv       <= 1'b0;
      s1_ctl_fall <= 1'b0;
    end else begin
      s1_rxd_rise <= rxd_rise;
      s1_rxd_fall <= rxd_fall;
      s1_dv       <= rx_ctl_rise;
      s1_ctl_fall <= rx_ctl_fall;
    end
  end

  // Byte formation, error decode and end-of-frame classification
  always_comb begin
    gig     = (phy_speed_status == SPEED_1000);
    // RX_ER = RX_DV xor (RX_DV xor RX_ER); only meaningful inside a frame
    cyc_err = s1_dv & (s1_dv ^ s1_ctl_fall);
    if (gig) begin
      byte_valid = s1_dv;
      byte_data  = {s1_rxd_fall, s1_rxd_rise};
      byte_err   = cyc_err;
    end else begin
      byte_valid = s1_dv & nib_phase;
      byte_data  = {s1_rxd_rise, nib_low};
      byte_err   = cyc_err | nib_err;
    end
    // At 10/100M a held byte is emitted while S1 shows the following low
    // nibble. If the live RX_DV pin has already dropped, that nibble is an
    // orphan: the held byte is the last one and the frame is marked bad.
    // This one-bit lookahead keeps the three-cycle latency for last bytes.
    odd_end   = ~gig & s1_dv & ~nib_phase & ~rx_ctl_rise;
    beat_last = ~s1_dv | odd_end;
    beat_user = beat_last & (frame_err | odd_end);
    load_s2   = byte_valid &
                ((state == DATA) || ((state == IDLE) && !STRIP_PREAMBLE));
  end

  // Nibble toggle and low-nibble store; toggle clears whenever RX_DV is low
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      nib_phase <= 1'b0;
      nib_low   <= 4'h0;
      nib_err   <= 1'b0;
    end else if (!s1_dv || gig) begin
      nib_phase <= 1'b0;
      nib_err   <= 1'b0;
    end else begin
      nib_phase <= ~nib_phase;
      if (!nib_phase) begin
        nib_low <= s1_rxd_rise;
        nib_err <= cyc_err;
      end
    end
  end

  // Sticky frame error, accumulated over every DV cycle including preamble
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else if (!s1_dv) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err | cyc_err;
    end
  end

  // Frame state machine, re-synchronising on every RX_DV=0
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      state <= WAIT_IDLE;
    end else begin
      case (state)
        WAIT_IDLE: if (!s1_dv) state <= IDLE;
        IDLE: begin
          if (s1_dv) state <= STRIP_PREAMBLE ? PREAMBLE : DATA;
        end
        PREAMBLE: begin
          if (!s1_dv) begin
            state <= IDLE;
          end else if (byte_valid) begin
            if (byte_err)                   state <= DROP;
            else if (byte_data == SFD_BYTE) state <= DATA;
            else if (byte_data != PRE_BYTE) state <= DROP;
          end
        end
        DATA:    if (!s1_dv) state <= IDLE;
        DROP:    if (!s1_dv) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // S2 holds each data byte for exactly one cycle before it is emitted
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= 8'h00;
    end else begin
      s2_valid <= load_s2;
      if (load_s2) s2_data <= byte_data;
    end
  end

  // Registered AXI-Stream outputs, zeroed whenever no beat is presented
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      rx_axis_rgmii_tdata  <= 8'h00;
      rx_axis_rgmii_tvalid <= 1'b0;
      rx_axis_rgmii_tlast  <= 1'b0;
      rx_axis_rgmii_tuser  <= 1'b0;
    end else if (s2_valid) begin
      rx_axis_rgmii_tdata  <= s2_data;
      rx_axis_rgmii_tvalid <= 1'b1;
      rx_axis_rgmii_tlast  <= beat_last;
      rx_axis_rgmii_tuser  <= beat_user;
    end else begin
      rx_axis_rgmii_tdata  <= 8'h00;
      rx_axis_rgmii_tvalid <= 1'b0;
      rx_axis_rgmii_tlast  <= 1'b0;
      rx_axis_rgmii_tuser  <= 1'b0;
    end
  end

  // In-band status sampled only during normal idle (not carrier extend)
  always_ff @(posedge rgmii_rxc or posedge reset) begin
    if (reset) begin
      inband_link_status   <= 1'b0;
      inband_speed_status  <= 2'd0;
      inband_duplex_status <= 1'b0;
    end else if (!s1_dv && !s1_ctl_fall) begin
      inband_link_status   <= s1_rxd_rise[0];
      inband_speed_status  <= s1_rxd_rise[2:1];
      inband_duplex_status <= s1_rxd_rise[3];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_rx
// Purpose  : Self-checking bench for rgmii_rx. A table of per-cycle input
//            records carries the beat each record should produce; expected
//            beats go to a scoreboard queue when driven and are compared
//            when the DUT presents tvalid. Reset and in-band status corner
//            cases are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rxd_rise;
  logic [3:0] rxd_fall;
  logic       rx_ctl_rise;
  logic       rx_ctl_fall;
  logic [1:0] phy_speed_status;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       link;
  logic [1:0] speed;
  logic       duplex;

  rgmii_rx #(.STRIP_PREAMBLE(1'b1)) dut (
    .rgmii_rxc            (clk),
    .reset                (reset),
    .rxd_rise             (rxd_rise),
    .rxd_fall             (rxd_fall),
    .rx_ctl_rise          (rx_ctl_rise),
    .rx_ctl_fall          (rx_ctl_fall),
    .phy_speed_status     (phy_speed_status),
    .rx_axis_rgmii_tdata  (tdata),
    .rx_axis_rgmii_tvalid (tvalid),
    .rx_axis_rgmii_tlast  (tlast),
    .rx_axis_rgmii_tuser  (tuser),
    .inband_link_status   (link),
    .inband_speed_status  (speed),
    .inband_duplex_status (duplex)
  );

  always #4 clk = ~clk;

  // One input cycle plus the beat it is expected to complete (if any)
  typedef struct {
    logic       dv;
    logic       er;
    logic [3:0] r;
    logic [3:0] f;
    logic [1:0] spd;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eu;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         due;
  } beat_t;

  vec_t  vec[$];
  beat_t sb[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic dv, input logic er, input logic [3:0] r,
                              input logic [3:0] f, input logic [1:0] spd);
    vec_t v;
    v.dv = dv; v.er = er; v.r = r; v.f = f; v.spd = spd;
    v.ev = 1'b0; v.ed = 8'h00; v.el = 1'b0; v.eu = 1'b0;
    return v;
  endfunction

  task automatic add_idle(input int n, input logic [1:0] spd, input logic [3:0] nib,
                          input logic er);
    for (int i = 0; i < n; i++) vec.push_back(mk(1'b0, er, nib, nib, spd));
  endtask

  task automatic add_gig(input logic [7:0] d, input logic er, input logic ev,
                         input logic el, input logic eu);
    vec_t v;
    v = mk(1'b1, er, d[3:0], d[7:4], 2'd2);
    v.ev = ev; v.ed = d; v.el = el; v.eu = eu;
    vec.push_back(v);
  endtask

  // Low nibble first; the expected beat rides on the high-nibble cycle
  task automatic add_mii(input logic [7:0] d, input logic [1:0] spd, input logic er_lo,
                         input logic er_hi, input logic ev, input logic el, input logic eu);
    vec_t v;
    vec.push_back(mk(1'b1, er_lo, d[3:0], d[3:0], spd));
    v = mk(1'b1, er_hi, d[7:4], d[7:4], spd);
    v.ev = ev; v.ed = d; v.el = el; v.eu = eu;
    vec.push_back(v);
  endtask

  task automatic add_pre_gig();
    for (int i = 0; i < 7; i++) add_gig(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_pre_mii(input logic [1:0] spd);
    for (int i = 0; i < 7; i++) add_mii(8'h55, spd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_mii(8'hD5, spd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    beat_t b;
    @(posedge clk);
    #1;
    rx_ctl_rise      = v.dv;
    rx_ctl_fall      = v.dv ^ v.er;
    rxd_rise         = v.r;
    rxd_fall         = v.f;
    phy_speed_status = v.spd;
    if (v.ev) begin
      b.d = v.ed; b.l = v.el; b.u = v.eu; b.due = cyc + 3;
      sb.push_back(b);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t e;
      checks++;
      if (tvalid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cyc=%0d: got data=%h last=%b user=%b, wanted no beat",
                   cyc, tdata, tlast, tuser);
        end else begin
          e = sb.pop_front();
          if (tdata !== e.d || tlast !== e.l || (e.l && tuser !== e.u) || cyc != e.due) begin
            errors++;
            $display("FAIL beat cyc=%0d: got data=%h last=%b user=%b, wanted data=%h last=%b user=%b at cyc=%0d",
                     cyc, tdata, tlast, tuser, e.d, e.l, e.u, e.due);
          end
        end
      end else if ({tdata, tlast, tuser} !== 10'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d: got data=%h last=%b user=%b, wanted all zero",
                 cyc, tdata, tlast, tuser);
      end
    end
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    rxd_rise = 4'h0; rxd_fall = 4'h0;
    rx_ctl_rise = 1'b0; rx_ctl_fall = 1'b0;
    phy_speed_status = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", {7'd0, tvalid}, 8'h00);
    chk("reset_tdata",  tdata,          8'h00);
    chk("reset_tlast",  {7'd0, tlast},  8'h00);
    chk("reset_tuser",  {7'd0, tuser},  8'h00);
    chk("reset_inband", {4'd0, link, speed, duplex}, 8'h00);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // ---------------- vector table ----------------
    add_idle(4, 2'd2, 4'h0, 1'b0);
    // 1000M: 64 data bytes 0x01..0x40
    add_pre_gig();
    for (int b = 1; b <= 64; b++) add_gig(8'(b), 1'b0, 1'b1, (b == 64), 1'b0);
    add_idle(3, 2'd2, 4'hF, 1'b1);           // carrier extend: no output
    add_idle(4, 2'd2, 4'h0, 1'b0);
    // 1000M: RX_ER on the 3rd of 10 data bytes
    add_pre_gig();
    for (int i = 0; i < 10; i++)
      add_gig(8'(8'h10 + i), (i == 2), 1'b1, (i == 9), (i == 9));
    add_idle(4, 2'd2, 4'h0, 1'b0);
    // bad preamble, then a good frame
    add_gig(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'h17, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gig(8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(4, 2'd2, 4'h0, 1'b0);
    add_pre_gig();
    add_gig(8'hC1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_gig(8'hC2, 1'b0, 1'b1, 1'b1, 1'b0);
    add_idle(4, 2'd2, 4'h0, 1'b0);
    // zero bytes after SFD, and a preamble-only frame
    add_pre_gig();
    add_idle(4, 2'd2, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) add_gig(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(4, 2'd2, 4'h0, 1'b0);
    // 100M: 0xA5, 0x3C
    add_idle(4, 2'd1, 4'h0, 1'b0);
    add_pre_mii(2'd1);
    add_mii(8'hA5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_mii(8'h3C, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_idle(4, 2'd1, 4'h0, 1'b0);
    // 100M: error on the low nibble of a middle byte
    add_pre_mii(2'd1);
    add_mii(8'h11, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_mii(8'h22, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_mii(8'h33, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_idle(4, 2'd1, 4'h0, 1'b0);
    // 10M: SFD plus 5 data nibbles -> partial nibble dropped, tuser on last
    add_idle(4, 2'd0, 4'h0, 1'b0);
    add_pre_mii(2'd0);
    add_mii(8'h12, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_mii(8'h34, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    vec.push_back(mk(1'b1, 1'b0, 4'h5, 4'h5, 2'd0));
    add_idle(4, 2'd0, 4'h0, 1'b0);
    add_idle(4, 2'd2, 4'h0, 1'b0);

    for (int i = 0; i < vec.size(); i++) drive(vec[i]);

    // ---------------- in-band status ----------------
    repeat (3) drive(mk(1'b0, 1'b0, 4'hD, 4'hD, 2'd2));
    @(negedge clk);
    chk("inband_up", {4'd0, link, speed, duplex}, {4'd0, 1'b1, 2'd2, 1'b1});
    repeat (3) drive(mk(1'b0, 1'b1, 4'h0, 4'h0, 2'd2));   // error idle
    @(negedge clk);
    chk("inband_hold_on_ext", {4'd0, link, speed, duplex}, {4'd0, 1'b1, 2'd2, 1'b1});
    repeat (3) drive(mk(1'b0, 1'b0, 4'h0, 4'h0, 2'd2));
    @(negedge clk);
    chk("inband_down", {4'd0, link, speed, duplex}, 8'h00);

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 7; i++) drive(mk(1'b1, 1'b0, 4'h5, 4'h5, 2'd2));
    drive(mk(1'b1, 1'b0, 4'h5, 4'hD, 2'd2));
    v = mk(1'b1, 1'b0, 4'h0, 4'hE, 2'd2);
    v.ev = 1'b1; v.ed = 8'hE0; v.el = 1'b0; v.eu = 1'b0;
    drive(v);
    for (int i = 1; i < 4; i++) drive(mk(1'b1, 1'b0, 4'(i), 4'hE, 2'd2));
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("reset_async_tvalid", {7'd0, tvalid}, 8'h00);
    for (int i = 4; i < 6; i++) drive(mk(1'b1, 1'b0, 4'(i), 4'hE, 2'd2));
    reset = 1'b0;
    for (int i = 6; i < 10; i++) drive(mk(1'b1, 1'b0, 4'(i), 4'hE, 2'd2));
    repeat (4) drive(mk(1'b0, 1'b0, 4'h0, 4'h0, 2'd2));
    vec.delete();
    add_pre_gig();
    add_gig(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    add_gig(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    add_idle(6, 2'd2, 4'h0, 1'b0);
    for (int i = 0; i < vec.size(); i++) drive(vec[i]);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgmii_rx.md
RGMII_RX -- requirements
Module: rgmii_rx

Interface
REQ-001 Parameter STRIP_PREAMBLE, default 1: 1 = discard preamble/SFD bytes; 0 = forward every byte while RX_DV is high.
REQ-002 rgmii_rxc  input  1  receive clock from PHY: 125 MHz at 1000M, 25 MHz at 100M, 2.5 MHz at 10M; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rxd_rise  input  4  RXD nibble captured on the rgmii_rxc rising edge (IDDR, same-edge-pipelined).
REQ-005 rxd_fall  input  4  RXD nibble captured on the falling edge.
REQ-006 rx_ctl_rise  input  1  RX_CTL rising-edge sample (RX_DV).
REQ-007 rx_ctl_fall  input  1  RX_CTL falling-edge sample (RX_DV xor RX_ER).
REQ-008 phy_speed_status  input  2  mode: 10M(0), 100M(1), 1000M(2); quasi-static, synchronous to rgmii_rxc.
REQ-009 rx_axis_rgmii_tdata  output  8  received byte.
REQ-010 rx_axis_rgmii_tvalid  output  1  one-cycle byte strobe; no tready, the receiver cannot be stalled.
REQ-011 rx_axis_rgmii_tlast  output  1  last byte of frame, qualified by tvalid.
REQ-012 rx_axis_rgmii_tuser  output  1  frame error, valid only with tlast.
REQ-013 inband_link_status  output  1  decoded in-band link: up(1), down(0).
REQ-014 inband_speed_status  output  2  decoded in-band speed, same encoding as phy_speed_status.
REQ-015 inband_duplex_status  output  1  decoded in-band duplex: full(1).

Function
REQ-016 The block SHALL register all IDDR inputs once (stage S1) before any decoding.
REQ-017 At 1000M, each S1 cycle with rx_ctl_rise=1 SHALL form the byte {rxd_fall, rxd_rise}.
REQ-018 At 10/100M, the block SHALL use only rxd_rise:
- The first RX_DV nibble is the low nibble and the second is the high nibble.
- The nibble toggle SHALL clear whenever RX_DV=0.
REQ-019 Per-byte error SHALL be rx_ctl_rise xor rx_ctl_fall; at 10/100M it SHALL be the OR over both nibble cycles.
REQ-020 Frame FSM states SHALL be WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP, with these transitions:
- WAIT_IDLE->IDLE: S1 RX_DV=0.
- IDLE->PREAMBLE: RX_DV=1; goes directly to DATA when STRIP_PREAMBLE=0.
- PREAMBLE: stays on byte 0x55; goes to DATA on 0xD5 (SFD not forwarded); goes to DROP on any other byte or a byte error; goes to IDLE on RX_DV=0.
- DATA->IDLE: RX_DV=0.
- DROP->IDLE: RX_DV=0.
REQ-021 In DATA, each byte SHALL be held in a one-byte buffer (S2) and emitted when the next byte is formed (tlast=0) or when RX_DV falls (tlast=1).
REQ-022 Latency: a byte completed in input cycle t (1000M: its DV cycle; 10/100M: its high-nibble cycle) SHALL appear on tvalid in cycle t+3, for both middle and last bytes.
REQ-023 tuser SHALL be the sticky OR of all byte errors from frame start (including preamble) to the end of the frame.
REQ-024 At 10/100M, if RX_DV falls after an odd nibble, the partial nibble SHALL be discarded and tuser SHALL be 1 on the last byte.
REQ-025 A frame with zero bytes after the SFD SHALL produce no output beats.
REQ-026 In the DROP state, and for PREAMBLE-only frames, the block SHALL produce no output beats.
REQ-027 Carrier extend and error idle (rx_ctl_rise=0, rx_ctl_fall=1) SHALL NOT produce output and SHALL NOT update the in-band status.
REQ-028 During normal inter-frame idle (rx_ctl_rise=0, rx_ctl_fall=0), the block SHALL update the in-band status outputs from rxd_rise: link=bit0, speed=bits[2:1], duplex=bit3.
REQ-029 When tvalid=0, tdata, tlast and tuser SHALL be 0.
REQ-030 A change of phy_speed_status in mid-frame is unsupported; the first frame after such a change may be corrupted, and the FSM SHALL re-sync at the next RX_DV=0.

Reset
REQ-031 Reset SHALL be asynchronous, active-high, and take effect immediately at any point, including mid-frame.
REQ-032 Reset values SHALL be: all AXIS outputs 0; in-band outputs 0 (link down, 10M, half duplex); S1/S2 cleared; nibble toggle 0; FSM state WAIT_IDLE.
REQ-033 After reset deasserts while RX_DV is high, the remainder of the current frame SHALL be discarded; reception SHALL resume only after RX_DV=0 is seen.

Verification
REQ-034 1000M, STRIP_PREAMBLE=1: send 7x0x55, 0xD5, 0x01..0x40, with error-free RX_CTL -> 64 beats 0x01..0x40; tlast only on 0x40; tuser=0; first beat 3 cycles after the 0x01 input cycle.
REQ-035 100M: send nibbles for 7x0x55, 0xD5, 0xA5, 0x3C, with the low nibble first -> beats 0xA5 then 0x3C(tlast=1, tuser=0); every beat 3 cycles after its high nibble.
REQ-036 1000M: raise RX_ER (rx_ctl_fall=0 with rx_ctl_rise=1) on the 3rd data byte of a 10-byte frame -> 10 beats, tuser=1 on the last beat.
REQ-037 10M, odd nibble count (SFD plus 5 data nibbles) -> 2 beats, tlast=1 on the 2nd beat with tuser=1, and the partial nibble discarded.
REQ-038 Bad preamble (0x55, 0x55, 0x17, ...) -> no beats; the next good frame is received intact.
REQ-039 Idle with rxd_rise=0xD, then 0x0 -> in-band link=1, speed=2, full duplex, then link=0 at 10M; with reset asserted mid-frame and released while RX_DV=1, no beats occur until after the next RX_DV=0.
